// File: rtl/operand_sel_stage.sv
// N:1 operand selector with a registered result and a one-entry skid behind it; one-cycle latency.
// Backpressure: ready_o depends only on registered skid occupancy, so ready_i never reaches ready_o combinationally.
module operand_sel_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_i,
  input  logic [SEL_W-1:0]         select_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         res_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     sel_err_o
);

  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);

  logic [WIDTH-1:0] main_q, main_d;
  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_vld_q, skid_vld_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_ok;
  logic [WIDTH-1:0] new_word;
  logic             accept;
  logic             drain;

  // Out-of-range selects capture zero rather than an undefined slice.
  always_comb begin
    sel_ok   = ({1'b0, select_i} < NUM_SRC_W);
    new_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_ok && (select_i == SEL_W'(k))) begin
        new_word = src_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign ready_o = !skid_vld_q && !rst_i;
  assign accept  = valid_i && ready_o;
  assign drain   = main_vld_q && ready_i;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    sel_err_d  = sel_err_q;

    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (drain) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      sel_err_d = sel_err_q | !sel_ok;
      if (!main_vld_q || ready_i) begin
        main_d     = new_word;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = new_word;
        skid_vld_d = 1'b1;
      end
    end else if (drain) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign res_o     = main_q;
  assign valid_o   = main_vld_q;
  assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_operand_sel_stage.sv
// Scoreboard bench for operand_sel_stage: a 4-source and a 3-source instance driven by directed vectors.
module tb_operand_sel_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 4-source instance
  logic         flush4 = 1'b0;
  logic [127:0] src4;
  logic [1:0]   sel4 = '0;
  logic         vin4 = 1'b0;
  logic         rdy_o4;
  logic [31:0]  res4;
  logic         vout4;
  logic         rdy_i4 = 1'b0;
  logic         err4;
  logic [31:0]  exp4 = '0;

  // 3-source instance
  logic         flush3 = 1'b0;
  logic [95:0]  src3;
  logic [1:0]   sel3 = '0;
  logic         vin3 = 1'b0;
  logic         rdy_o3;
  logic [31:0]  res3;
  logic         vout3;
  logic         rdy_i3 = 1'b0;
  logic         err3;
  logic [31:0]  exp3 = '0;

  assign src4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  assign src3 = {32'h33333333, 32'h22222222, 32'h11111111};

  operand_sel_stage #(.WIDTH(32), .NUM_SRC(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush4), .src_i(src4), .select_i(sel4),
    .valid_i(vin4), .ready_o(rdy_o4), .res_o(res4), .valid_o(vout4),
    .ready_i(rdy_i4), .sel_err_o(err4)
  );

  operand_sel_stage #(.WIDTH(32), .NUM_SRC(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush3), .src_i(src3), .select_i(sel3),
    .valid_i(vin3), .ready_o(rdy_o3), .res_o(res3), .valid_o(vout3),
    .ready_i(rdy_i3), .sel_err_o(err3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] q4[$];
  logic [31:0] q3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue side: a handshake-accepted vector queues its hand-computed result; flush discards queued words.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (flush4) q4.delete();
      else if (vin4 && rdy_o4) q4.push_back(exp4);
      if (flush3) q3.delete();
      else if (vin3 && rdy_o3) q3.push_back(exp3);
    end
  end

  // Output side: every drained word must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && vout4 && rdy_i4) begin
      if (q4.size() == 0) chk("dut4 unexpected output", res4, 32'hxxxxxxxx);
      else chk("dut4 res_o", res4, q4.pop_front());
    end
    if (!rst && vout3 && rdy_i3) begin
      if (q3.size() == 0) chk("dut3 unexpected output", res3, 32'hxxxxxxxx);
      else chk("dut3 res_o", res3, q3.pop_front());
    end
  end

  initial begin
    // 1. Reset with valid_i asserted
    rst  = 1'b1;
    vin4 = 1'b1;
    vin3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset ready_o dut4", rdy_o4, 0);
      chk("reset ready_o dut3", rdy_o3, 0);
    end
    step();
    rst  = 1'b0;
    vin4 = 1'b0;
    vin3 = 1'b0;
    #1;
    chk("post-reset valid_o", vout4, 0);
    chk("post-reset res_o", res4, 0);
    chk("post-reset sel_err_o", err4, 0);
    chk("post-reset ready_o", rdy_o4, 1);

    // 2. Streaming at full rate
    rdy_i4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel4 = 2'(k);
      exp4 = 32'h11111111 * (k + 1);
      vin4 = 1'b1;
      step();
      chk("stream valid_o", vout4, 1);
      chk("stream ready_o", rdy_o4, 1);
    end
    vin4 = 1'b0;
    step();
    chk("stream idle valid_o", vout4, 0);
    step();

    // 3. Backpressure: A in main, B in skid, C held off
    rdy_i4 = 1'b0;
    sel4 = 2'd1; exp4 = 32'h22222222; vin4 = 1'b1;
    step();
    sel4 = 2'd2; exp4 = 32'h33333333;
    step();
    chk("bp ready_o after B", rdy_o4, 0);
    chk("bp valid_o", vout4, 1);
    chk("bp main holds A", res4, 32'h22222222);
    sel4 = 2'd3; exp4 = 32'h44444444;
    step();
    step();
    chk("bp C not accepted", rdy_o4, 0);
    chk("bp main still A", res4, 32'h22222222);
    rdy_i4 = 1'b1;
    step();
    chk("bp B moved to main", res4, 32'h33333333);
    chk("bp ready_o reopens", rdy_o4, 1);
    step();
    chk("bp C in main", res4, 32'h44444444);
    vin4 = 1'b0;
    step();
    step();
    chk("bp drained valid_o", vout4, 0);

    // 5. Flush with both entries full and a same-cycle valid word
    rdy_i4 = 1'b0;
    sel4 = 2'd0; exp4 = 32'h11111111; vin4 = 1'b1;
    step();
    sel4 = 2'd1; exp4 = 32'h22222222;
    step();
    chk("flush pre ready_o", rdy_o4, 0);
    sel4 = 2'd2; exp4 = 32'h33333333; flush4 = 1'b1;
    step();
    chk("flush valid_o", vout4, 0);
    chk("flush ready_o", rdy_o4, 1);
    chk("flush res_o holds", res4, 32'h11111111);
    flush4 = 1'b0; vin4 = 1'b0; rdy_i4 = 1'b1;
    step();
    step();
    chk("flush nothing emerges", vout4, 0);

    // 6. Accept and drain together with skid empty
    rdy_i4 = 1'b0;
    sel4 = 2'd0; exp4 = 32'h11111111; vin4 = 1'b1;
    step();
    rdy_i4 = 1'b1;
    sel4 = 2'd3; exp4 = 32'h44444444;
    step();
    chk("replace res_o", res4, 32'h44444444);
    chk("replace valid_o", vout4, 1);
    chk("replace ready_o", rdy_o4, 1);
    vin4 = 1'b0;
    step();
    step();

    // 4. Out-of-range select on the 3-source instance
    rdy_i3 = 1'b1;
    sel3 = 2'd3; exp3 = 32'h0; vin3 = 1'b1; flush3 = 1'b1;
    step();
    chk("oor in flush ignored", err3, 0);
    chk("oor in flush no output", vout3, 0);
    flush3 = 1'b0;
    step();
    chk("oor res_o", res3, 32'h0);
    chk("oor valid_o", vout3, 1);
    chk("oor sel_err_o", err3, 1);
    sel3 = 2'd1; exp3 = 32'h22222222;
    step();
    chk("oor legal res_o", res3, 32'h22222222);
    chk("oor sticky after legal", err3, 1);
    vin3 = 1'b0;
    step();
    flush3 = 1'b1;
    step();
    flush3 = 1'b0;
    chk("oor sticky after flush", err3, 1);
    chk("dut4 no spurious err", err4, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("oor cleared by reset", err3, 0);
    step();

    chk("dut4 scoreboard empty", 32'(q4.size()), 0);
    chk("dut3 scoreboard empty", 32'(q3.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
